// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions for the execute/hazard slice.
// Holds opcode/funct3 constants, the bubble encoding and the register-field helpers.
package rv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // All-zero word has opcode 0, so it neither reads nor writes a register.
  localparam logic [31:0] NOP_BUBBLE = 32'h0000_0000;

  typedef enum logic [3:0] {
    ALU_ZERO,
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_PASS_B,
    ALU_JALR
  } alu_op_e;

  function automatic logic [4:0] get_rd(input logic [31:0] ins);
    return ins[11:7];
  endfunction

  function automatic logic [4:0] get_rs1(input logic [31:0] ins);
    return ins[19:15];
  endfunction

  function automatic logic [4:0] get_rs2(input logic [31:0] ins);
    return ins[24:20];
  endfunction

  function automatic logic writes_rd(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    return ((op == OPC_LOAD) || (op == OPC_OP_IMM) || (op == OPC_OP) ||
            (op == OPC_LUI) || (op == OPC_AUIPC) || (op == OPC_JAL) ||
            (op == OPC_JALR)) && (ins[11:7] != 5'd0);
  endfunction

  function automatic logic uses_rs1(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    return (op == OPC_OP) || (op == OPC_OP_IMM) || (op == OPC_LOAD) ||
           (op == OPC_STORE) || (op == OPC_BRANCH) || (op == OPC_JALR);
  endfunction

  function automatic logic uses_rs2(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    return (op == OPC_OP) || (op == OPC_STORE) || (op == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/rv_alu_core.sv
// Combinational ALU datapath: decodes opcode/funct3/funct7[5] into an operation
// and evaluates it on the externally muxed operands. The top registers the result.
module rv_alu_core
  import rv_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            funct7_b5,
  input  logic [BITS-1:0] alu_a,
  input  logic [BITS-1:0] alu_b,
  output logic [BITS-1:0] alu_res
);

  alu_op_e         alu_op;
  logic [BITS-1:0] sum;
  logic [BITS-1:0] diff;
  logic [4:0]      shamt;

  assign sum   = alu_a + alu_b;
  assign diff  = alu_a - alu_b;
  assign shamt = alu_b[4:0];

  always_comb begin
    alu_op = ALU_ZERO;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        case (funct3)
          // Immediates can set bit 30, so SUB is only legal for register-register ops.
          F3_ADD:  alu_op = ((opcode == OPC_OP) && funct7_b5) ? ALU_SUB : ALU_ADD;
          F3_SLL:  alu_op = ALU_SLL;
          F3_SLT:  alu_op = ALU_SLT;
          F3_SLTU: alu_op = ALU_SLTU;
          F3_XOR:  alu_op = ALU_XOR;
          F3_SR:   alu_op = funct7_b5 ? ALU_SRA : ALU_SRL;
          F3_OR:   alu_op = ALU_OR;
          F3_AND:  alu_op = ALU_AND;
          default: alu_op = ALU_ZERO;
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_AUIPC, OPC_JAL, OPC_BRANCH: alu_op = ALU_ADD;
      OPC_JALR: alu_op = ALU_JALR;
      OPC_LUI:  alu_op = ALU_PASS_B;
      default:  alu_op = ALU_ZERO;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:    alu_res = sum;
      ALU_SUB:    alu_res = diff;
      ALU_SLL:    alu_res = alu_a << shamt;
      ALU_SLT:    alu_res = {{(BITS-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      ALU_SLTU:   alu_res = {{(BITS-1){1'b0}}, (alu_a < alu_b)};
      ALU_XOR:    alu_res = alu_a ^ alu_b;
      ALU_SRL:    alu_res = alu_a >> shamt;
      ALU_SRA:    alu_res = $unsigned($signed(alu_a) >>> shamt);
      ALU_OR:     alu_res = alu_a | alu_b;
      ALU_AND:    alu_res = alu_a & alu_b;
      ALU_PASS_B: alu_res = alu_b;
      ALU_JALR:   alu_res = {sum[BITS-1:1], 1'b0};
      default:    alu_res = '0;
    endcase
  end

endmodule

// File: rtl/rv_exec_hazard.sv
// Execute-side control: registered ALU result and branch redirect, plus a RAW
// hazard gate on fetched instructions. Hazard history is built only with RV_HAZARD_EN.
module rv_exec_hazard
  import rv_pkg::*;
#(
  parameter int BITS      = 32,
  parameter int HAZ_DEPTH = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instr,
  input  logic [31:0]     ex_instr,
  input  logic [BITS-1:0] alu_a,
  input  logic [BITS-1:0] alu_b,
  input  logic [BITS-1:0] rs1_val,
  input  logic [BITS-1:0] rs2_val,
  output logic [BITS-1:0] res,
  output logic            br,
  output logic            hz,
  output logic [31:0]     hz_in
);

  logic [6:0]      ex_op;
  logic [2:0]      ex_f3;
  logic [BITS-1:0] alu_res;
  logic [BITS-1:0] res_reg;
  logic            br_reg;
  logic            br_next;
  logic            unused_ex;

  assign ex_op     = ex_instr[6:0];
  assign ex_f3     = ex_instr[14:12];
  assign unused_ex = ^{ex_instr[31], ex_instr[29:15], ex_instr[11:7]};

  rv_alu_core #(
    .BITS(BITS)
  ) u_alu_core (
    .opcode    (ex_op),
    .funct3    (ex_f3),
    .funct7_b5 (ex_instr[30]),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_res   (alu_res)
  );

  always_comb begin
    br_next = 1'b0;
    case (ex_op)
      OPC_BRANCH: begin
        case (ex_f3)
          F3_BEQ:  br_next = (rs1_val == rs2_val);
          F3_BNE:  br_next = (rs1_val != rs2_val);
          F3_BLT:  br_next = ($signed(rs1_val) < $signed(rs2_val));
          F3_BGE:  br_next = ($signed(rs1_val) >= $signed(rs2_val));
          F3_BLTU: br_next = (rs1_val < rs2_val);
          F3_BGEU: br_next = (rs1_val >= rs2_val);
          default: br_next = 1'b0;
        endcase
      end
      OPC_JAL, OPC_JALR: br_next = 1'b1;
      default: br_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_reg <= '0;
      br_reg  <= 1'b0;
    end else begin
      res_reg <= alu_res;
      br_reg  <= br_next;
    end
  end

  assign res = res_reg;
  assign br  = br_reg;

`ifdef RV_HAZARD_EN
  // Entry 0 holds the instruction issued last cycle; entry HAZ_DEPTH-1 the oldest.
  logic [4:0]           hist_rd_reg [HAZ_DEPTH];
  logic [HAZ_DEPTH-1:0] hist_v_reg;
  logic [HAZ_DEPTH-1:0] match;
  logic [4:0]           src1;
  logic [4:0]           src2;
  logic                 use1;
  logic                 use2;
  logic                 hz_raw;

  assign src1 = get_rs1(instr);
  assign src2 = get_rs2(instr);
  assign use1 = uses_rs1(instr) && (src1 != 5'd0);
  assign use2 = uses_rs2(instr) && (src2 != 5'd0);

  genvar gi;
  generate
    for (gi = 0; gi < HAZ_DEPTH; gi++) begin : g_match
      assign match[gi] = hist_v_reg[gi] &&
                         ((use1 && (src1 == hist_rd_reg[gi])) ||
                          (use2 && (src2 == hist_rd_reg[gi])));
    end
  endgenerate

  assign hz_raw = |match;

  // A redirect squashes the fetched word, so a stall would be meaningless.
  always_comb begin
    hz    = 1'b0;
    hz_in = instr;
    if (br_reg) begin
      hz_in = NOP_BUBBLE;
    end else if (hz_raw) begin
      hz    = 1'b1;
      hz_in = NOP_BUBBLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_v_reg <= '0;
      for (int i = 0; i < HAZ_DEPTH; i++) begin
        hist_rd_reg[i] <= 5'd0;
      end
    end else begin
      hist_rd_reg[0] <= get_rd(hz_in);
      hist_v_reg[0]  <= br_reg ? 1'b0 : writes_rd(hz_in);
      for (int i = 1; i < HAZ_DEPTH; i++) begin
        hist_rd_reg[i] <= hist_rd_reg[i-1];
        hist_v_reg[i]  <= br_reg ? 1'b0 : hist_v_reg[i-1];
      end
    end
  end
`else
  assign hz    = 1'b0;
  assign hz_in = br_reg ? NOP_BUBBLE : instr;
`endif

endmodule

// File: tb/tb_rv_exec_hazard.sv
// Directed bench for rv_exec_hazard: table of ALU/branch vectors plus hand
// sequences for stall, no-stall, flush and asynchronous reset.
module tb_rv_exec_hazard;

  localparam logic [6:0] T_OP    = 7'b0110011;
  localparam logic [6:0] T_OPI   = 7'b0010011;
  localparam logic [6:0] T_LUI   = 7'b0110111;
  localparam logic [6:0] T_AUIPC = 7'b0010111;
  localparam logic [6:0] T_JAL   = 7'b1101111;
  localparam logic [6:0] T_JALR  = 7'b1100111;
  localparam logic [6:0] T_BR    = 7'b1100011;
  localparam logic [6:0] T_ST    = 7'b0100011;
  localparam logic [6:0] T_LD    = 7'b0000011;
  localparam logic [6:0] T_FENCE = 7'b0001111;

`ifdef RV_HAZARD_EN
  localparam bit HAZ_ON = 1'b1;
`else
  localparam bit HAZ_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic [31:0] ex_instr;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] res;
  logic        br;
  logic        hz;
  logic [31:0] hz_in;

  rv_exec_hazard #(
    .BITS(32),
    .HAZ_DEPTH(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .instr    (instr),
    .ex_instr (ex_instr),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .rs1_val  (rs1_val),
    .rs2_val  (rs2_val),
    .res      (res),
    .br       (br),
    .hz       (hz),
    .hz_in    (hz_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] eres;
    logic        ebr;
  } vec_t;

  vec_t vt [26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    instr    = 32'h0;
    ex_instr = 32'h0;
    repeat (4) tick();
  endtask

  logic [31:0] addi_x5, add_x6, sw_x5, lui_x8, add_x7_x0, addi_x0;

  initial begin
    addi_x5   = enc_r(7'h00, 5'd1, 5'd0, 3'b000, 5'd5, T_OPI);   // addi x5,x0,1
    add_x6    = enc_r(7'h00, 5'd5, 5'd5, 3'b000, 5'd6, T_OP);    // add x6,x5,x5
    sw_x5     = enc_r(7'h00, 5'd5, 5'd1, 3'b010, 5'd0, T_ST);    // sw x5,0(x1)
    lui_x8    = enc_r(7'h00, 5'd0, 5'd5, 3'b000, 5'd8, T_LUI);   // rs1 field = 5, unused
    add_x7_x0 = enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd7, T_OP);    // add x7,x0,x0
    addi_x0   = enc_r(7'h00, 5'd5, 5'd0, 3'b000, 5'd0, T_OPI);   // addi x0,x0,5

    vt[0]  = '{"sub",   enc_r(7'h20,5'd2,5'd1,3'b000,5'd3,T_OP), 32'd5, 32'd7, 0, 0, 32'hFFFF_FFFE, 1'b0};
    vt[1]  = '{"add",   enc_r(7'h00,5'd2,5'd1,3'b000,5'd3,T_OP), 32'hFFFF_FFFF, 32'd2, 0, 0, 32'd1, 1'b0};
    vt[2]  = '{"sra",   enc_r(7'h20,5'd2,5'd1,3'b101,5'd3,T_OP), 32'h8000_0000, 32'd4, 0, 0, 32'hF800_0000, 1'b0};
    vt[3]  = '{"srl",   enc_r(7'h00,5'd2,5'd1,3'b101,5'd3,T_OP), 32'h8000_0000, 32'd4, 0, 0, 32'h0800_0000, 1'b0};
    vt[4]  = '{"sll",   enc_r(7'h00,5'd2,5'd1,3'b001,5'd3,T_OP), 32'd1, 32'h23, 0, 0, 32'd8, 1'b0};
    vt[5]  = '{"slt",   enc_r(7'h00,5'd2,5'd1,3'b010,5'd3,T_OP), 32'hFFFF_FFFF, 32'd1, 0, 0, 32'd1, 1'b0};
    vt[6]  = '{"sltu",  enc_r(7'h00,5'd2,5'd1,3'b011,5'd3,T_OP), 32'hFFFF_FFFF, 32'd1, 0, 0, 32'd0, 1'b0};
    vt[7]  = '{"xor",   enc_r(7'h00,5'd2,5'd1,3'b100,5'd3,T_OP), 32'hF0F0, 32'hFF00, 0, 0, 32'h0FF0, 1'b0};
    vt[8]  = '{"or",    enc_r(7'h00,5'd2,5'd1,3'b110,5'd3,T_OP), 32'hF0F0, 32'hFF00, 0, 0, 32'hFFF0, 1'b0};
    vt[9]  = '{"and",   enc_r(7'h00,5'd2,5'd1,3'b111,5'd3,T_OP), 32'hF0F0, 32'hFF00, 0, 0, 32'hF000, 1'b0};
    vt[10] = '{"addi7", enc_r(7'h20,5'd5,5'd1,3'b000,5'd3,T_OPI), 32'd5, 32'd7, 0, 0, 32'd12, 1'b0};
    vt[11] = '{"srai",  enc_r(7'h20,5'd4,5'd1,3'b101,5'd3,T_OPI), 32'h8000_0000, 32'h404, 0, 0, 32'hF800_0000, 1'b0};
    vt[12] = '{"lui",   enc_r(7'h00,5'd0,5'd0,3'b000,5'd3,T_LUI), 32'd99, 32'h1234_5000, 0, 0, 32'h1234_5000, 1'b0};
    vt[13] = '{"auipc", enc_r(7'h00,5'd0,5'd0,3'b000,5'd3,T_AUIPC), 32'h1000, 32'h2000, 0, 0, 32'h3000, 1'b0};
    vt[14] = '{"jalr",  enc_r(7'h00,5'd0,5'd1,3'b000,5'd1,T_JALR), 32'h103, 32'h0, 0, 0, 32'h102, 1'b1};
    vt[15] = '{"jal",   enc_r(7'h00,5'd0,5'd0,3'b000,5'd1,T_JAL), 32'h100, 32'h20, 0, 0, 32'h120, 1'b1};
    vt[16] = '{"blt",   enc_r(7'h00,5'd2,5'd1,3'b100,5'd0,T_BR), 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, 32'h210, 1'b1};
    vt[17] = '{"bltu",  enc_r(7'h00,5'd2,5'd1,3'b110,5'd0,T_BR), 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, 32'h210, 1'b0};
    vt[18] = '{"beq",   enc_r(7'h00,5'd2,5'd1,3'b000,5'd0,T_BR), 32'h0, 32'h0, 32'd5, 32'd5, 32'h0, 1'b1};
    vt[19] = '{"bne",   enc_r(7'h00,5'd2,5'd1,3'b001,5'd0,T_BR), 32'h0, 32'h0, 32'd5, 32'd5, 32'h0, 1'b0};
    vt[20] = '{"bge",   enc_r(7'h00,5'd2,5'd1,3'b101,5'd0,T_BR), 32'h0, 32'h4, 32'd1, 32'hFFFF_FFFF, 32'h4, 1'b1};
    vt[21] = '{"bgeu",  enc_r(7'h00,5'd2,5'd1,3'b111,5'd0,T_BR), 32'h0, 32'h4, 32'd1, 32'hFFFF_FFFF, 32'h4, 1'b0};
    vt[22] = '{"br010", enc_r(7'h00,5'd2,5'd1,3'b010,5'd0,T_BR), 32'h0, 32'h0, 32'd5, 32'd5, 32'h0, 1'b0};
    vt[23] = '{"fence", enc_r(7'h00,5'd0,5'd0,3'b000,5'd0,T_FENCE), 32'd5, 32'd7, 0, 0, 32'h0, 1'b0};
    vt[24] = '{"store", enc_r(7'h00,5'd2,5'd1,3'b010,5'd0,T_ST), 32'h1000, 32'hFFFF_FFFC, 0, 0, 32'hFFC, 1'b0};
    vt[25] = '{"load",  enc_r(7'h00,5'd0,5'd1,3'b010,5'd3,T_LD), 32'hFFFF_FFFF, 32'd1, 0, 0, 32'h0, 1'b0};

    // Reset state
    rst_n = 1'b0; instr = addi_x5; ex_instr = 32'h0;
    alu_a = 32'h0; alu_b = 32'h0; rs1_val = 32'h0; rs2_val = 32'h0;
    #3;
    chk("rst_res", res, 32'h0);
    chk("rst_br", 32'(br), 32'h0);
    chk("rst_hz", 32'(hz), 32'h0);
    chk("rst_hz_in", hz_in, addi_x5);
    $display("reset: res=%h br=%b hz=%b hz_in=%h", res, br, hz, hz_in);
    instr = 32'h0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // ALU / branch table
    for (int i = 0; i < 26; i++) begin
      ex_instr = vt[i].ins; alu_a = vt[i].a; alu_b = vt[i].b;
      rs1_val = vt[i].r1; rs2_val = vt[i].r2;
      tick();
      chk({vt[i].name, "_res"}, res, vt[i].eres);
      chk({vt[i].name, "_br"}, 32'(br), 32'(vt[i].ebr));
      $display("vec %0d %s: res=%h br=%b", i, vt[i].name, res, br);
    end
    drain();

    // RAW stall: producer then dependent reader
    instr = addi_x5;
    #1;
    chk("raw_prod_hz", 32'(hz), 32'h0);
    chk("raw_prod_in", hz_in, addi_x5);
    tick();
    instr = add_x6;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("raw_stall_hz", 32'(hz), 32'(HAZ_ON));
      chk("raw_stall_in", hz_in, HAZ_ON ? 32'h0 : add_x6);
      $display("raw cycle %0d: hz=%b hz_in=%h", k, hz, hz_in);
      tick();
    end
    #1;
    chk("raw_pass_hz", 32'(hz), 32'h0);
    chk("raw_pass_in", hz_in, add_x6);
    $display("raw release: hz=%b hz_in=%h", hz, hz_in);
    drain();

    // Store rs2 dependence, unused LUI rs1 field, and x0 reader
    instr = addi_x5;
    tick();
    instr = sw_x5;
    #1;
    chk("sw_rs2_hz", 32'(hz), 32'(HAZ_ON));
    instr = lui_x8;
    #1;
    chk("lui_nors1_hz", 32'(hz), 32'h0);
    chk("lui_nors1_in", hz_in, lui_x8);
    instr = add_x7_x0;
    #1;
    chk("x0_read_hz", 32'(hz), 32'h0);
    $display("src-use checks: hz=%b hz_in=%h", hz, hz_in);
    drain();

    // Producer writing x0 never blocks
    instr = addi_x0;
    tick();
    instr = enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd9, T_OP);
    #1;
    chk("rd0_hz", 32'(hz), 32'h0);
    $display("rd=x0 producer: hz=%b", hz);
    drain();

    // Flush while stalled
    instr = addi_x5;
    tick();
    instr = add_x6; ex_instr = enc_r(7'h00,5'd0,5'd0,3'b000,5'd1,T_JAL);
    alu_a = 32'h40; alu_b = 32'h8;
    #1;
    chk("flush_pre_hz", 32'(hz), 32'(HAZ_ON));
    tick();
    chk("flush_br", 32'(br), 32'h1);
    chk("flush_res", res, 32'h48);
    chk("flush_hz", 32'(hz), 32'h0);
    chk("flush_in", hz_in, 32'h0);
    ex_instr = 32'h0;
    tick();
    chk("post_flush_br", 32'(br), 32'h0);
    chk("post_flush_hz", 32'(hz), 32'h0);
    chk("post_flush_in", hz_in, add_x6);
    $display("flush: br=%b hz=%b hz_in=%h", br, hz, hz_in);
    drain();

    // Asynchronous reset in the middle of a stall
    instr = addi_x5;
    tick();
    instr = add_x6; ex_instr = enc_r(7'h00,5'd2,5'd1,3'b000,5'd0,T_BR);
    alu_a = 32'd4; alu_b = 32'd4; rs1_val = 32'd1; rs2_val = 32'd2;
    tick();
    chk("mid_res", res, 32'd8);
    chk("mid_hz", 32'(hz), 32'(HAZ_ON));
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_hz", 32'(hz), 32'h0);
    chk("arst_in", hz_in, add_x6);
    chk("arst_res", res, 32'h0);
    chk("arst_br", 32'(br), 32'h0);
    $display("async reset mid-stall: hz=%b res=%h br=%b", hz, res, br);
    rst_n = 1'b1;
    ex_instr = enc_r(7'h00,5'd0,5'd0,3'b000,5'd1,T_JAL);
    alu_a = 32'd1; alu_b = 32'd1;
    tick();
    chk("pre_rst_br", 32'(br), 32'h1);
    chk("pre_rst_res", res, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst2_br", 32'(br), 32'h0);
    chk("arst2_res", res, 32'h0);
    chk("arst2_in", hz_in, add_x6);
    $display("async reset with redirect: br=%b res=%h hz_in=%h", br, res, hz_in);
    rst_n = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_exec_hazard.md
# rv_exec_hazard

Execute-side control block of the 5-stage RV32I pipeline. It bundles three functions:

- a registered ALU that computes arithmetic, address and jump/branch targets;
- a registered branch resolver that decides whether control flow is redirected;
- a combinational RAW hazard detector that gates fetched instructions into decode, substituting bubbles while a source register is still pending write-back.

It sits between imem/regfile read and the EX/MEM pipeline registers.

## Interface
- `BITS`, default 32: datapath width.
- `HAZ_DEPTH`, default 3: number of issued instructions tracked as pending writers (ID, EX, MEM stages).
- `clk`, input, 1: single clock; all state updates on rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `instr`, input, 32: instruction fetched this cycle.
- `ex_instr`, input, 32: instruction currently in ID/EX (drives ALU and branch decode).
- `alu_a`, input, `BITS`: ALU operand A (rs1 or PC, muxed outside).
- `alu_b`, input, `BITS`: ALU operand B (rs2 or immediate, muxed outside).
- `rs1_val`, input, `BITS`: raw rs1 data for branch compare.
- `rs2_val`, input, `BITS`: raw rs2 data for branch compare.
- `res`, output, `BITS`: registered ALU result.
- `br`, output, 1: registered branch-taken / redirect.
- `hz`, output, 1: stall request (hold PC and the PC pipeline).
- `hz_in`, output, 32: instruction forwarded to decode (`instr`, or bubble).

## Operation
- Bubble encoding is `32'h0000_0000`. It is treated as "no writer".
- ALU decodes `ex_instr` opcode, funct3 and funct7[5]:
  - OP / OP-IMM: ADD/SUB (SUB only for OP with funct7[5]=1), SLL, SLT, SLTU, XOR, SRL/SRA (funct7[5]), OR, AND.
  - Shift amount is `alu_b[4:0]`.
  - SLT/SLTU produce 0/1.
  - LOAD, STORE, AUIPC, JAL, BRANCH: `a+b`.
  - JALR: `(a+b) & ~1`.
  - LUI: `b`.
  - Any other opcode: 0.
- All arithmetic wraps modulo 2^BITS.
- Branch resolver, for opcode BRANCH:
  - funct3 000 BEQ, 001 BNE, 100 BLT signed, 101 BGE signed, 110 BLTU, 111 BGEU.
  - funct3 010 and 011 are not taken.
  - JAL and JALR are always taken.
  - All other opcodes are not taken.
- Hazard detector:
  - Keeps a `HAZ_DEPTH`-entry history of destination registers of issued instructions.
  - An entry is valid only for writing opcodes (LOAD, OP-IMM, OP, LUI, AUIPC, JAL, JALR) with rd≠0.
  - rs1 is used by OP, OP-IMM, LOAD, STORE, BRANCH and JALR.
  - rs2 is used by OP, STORE and BRANCH.
  - x0 never conflicts.
  - `hz`=1 when any used source of `instr` matches any valid history entry.
- When `hz`=1, `hz_in` = bubble; otherwise `hz_in` = `instr`.
- History shifts every cycle:
  - the new entry is `hz_in`'s rd and valid flag;
  - the oldest entry is dropped.
- When `br`=1, all history entries are invalidated. Flushed instructions never write back.
- `br` has priority over `hz`: while `br`=1, `hz` is forced 0 and `hz_in` = bubble.

## Timing
- `res` and `br` have 1-cycle latency. Inputs sampled at edge N appear after edge N, aligned with the instruction's EX/MEM register.
- `hz` and `hz_in` are combinational from `instr`, the history and `br`. There is no registered delay.
- History is updated on the same edge as the pipeline registers.
- A dependent instruction issued right after its producer stalls exactly `HAZ_DEPTH` cycles, then passes.
- Reset (async assert, sync release):
  - `res`=0, `br`=0;
  - history all invalid, so `hz`=0 and `hz_in`=`instr`.
- Reset mid-stall drops the stall immediately.

## Configuration
- `RV_HAZARD_EN`: when defined, the hazard detector operates as described.
- When undefined:
  - `hz` is tied 0;
  - `hz_in` = `instr`, except bubble when `br`=1;
  - no history logic is synthesized.

## Structure
- Shared package `rv_pkg`:
  - opcode constants (LOAD, STORE, OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH);
  - funct3 constants for ALU and branch;
  - `NOP_BUBBLE`;
  - field-extraction helper functions for rd/rs1/rs2.
- One sub-module, `rv_alu_core`: combinational ALU datapath, registered by the top.

## Test plan
- **Arithmetic.** `ex_instr`=SUB, a=5, b=7 -> `res`=`32'hFFFF_FFFE` one cycle later. SRA of `32'h8000_0000` by 4 -> `32'hF800_0000`.
- **Branch.** BLT with rs1=`32'hFFFF_FFFF`, rs2=1 -> `br`=1. Same operands with BLTU -> `br`=0. JALR with a=`0x103`, b=0 -> `res`=`0x102` and `br`=1.
- **RAW stall.** Issue `addi x5,x0,1`, then `add x6,x5,x5` -> `hz`=1 with bubble `hz_in` for 3 cycles, then `hz_in`=add.
- **No stall.** rd=x0 producer followed by a reader of x0 -> `hz`=0.
- **Flush.** `br`=1 while a dependent instruction is stalled -> history cleared, `hz_in` bubble, and `hz`=0 on the next cycle.
- **Reset.** Assert `rst_n`=0 asynchronously mid-stall -> `hz`=0, `res`=0, `br`=0 immediately.
